// File: rtl/i2s_capture_rx.sv
//------------------------------------------------------------------------------
// Module   : i2s_capture_rx
// Purpose  : I2S record-path receiver; oversampled deserializer + stereo FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module i2s_capture_rx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               i2s_bclk,
  input  logic                               i2s_lrclk,
  input  logic                               i2s_sdat,
  output logic [2*SAMPLE_WIDTH-1:0]          m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  output logic                               short_err,
  input  logic                               clr_flags
);

  localparam int IW = $clog2(SAMPLE_WIDTH + 2);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = 2 * SAMPLE_WIDTH;
  localparam logic [IW-1:0] c_sw_idx  = IW'(SAMPLE_WIDTH);
  localparam logic [IW-1:0] c_idx_max = IW'(SAMPLE_WIDTH + 1);
  localparam logic [LW-1:0] c_full    = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2,
    WAIT_L    = 2'd3
  } state_t;

  logic [2:0]              bclk_q;
  logic [1:0]              lr_sync_q;
  logic [1:0]              sd_sync_q;
  logic                    lr_prev_q;
  logic [IW-1:0]           bit_idx_q;
  logic [SAMPLE_WIDTH-2:0] shift_q;
  state_t                  state_q;
  logic [SAMPLE_WIDTH-1:0] left_q;
  logic                    push_q;
  logic [DW-1:0]           pair_q;
  logic [DW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [LW-1:0]           level_q;

  logic                    w_rise;
  logic                    w_lr;
  logic                    w_sd;
  logic                    w_slot_start;
  logic [IW-1:0]           w_idx_next;
  logic                    w_word_done;
  logic                    w_short;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push_ok;
  logic [LW-1:0]           w_level_d;

  // bclk_q[1:0] synchronise, bclk_q[2] is the previous sample for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_q    <= '0;
      lr_sync_q <= '0;
      sd_sync_q <= '0;
    end else begin
      bclk_q    <= {bclk_q[1:0], i2s_bclk};
      lr_sync_q <= {lr_sync_q[0], i2s_lrclk};
      sd_sync_q <= {sd_sync_q[0], i2s_sdat};
    end
  end

  assign w_rise       = bclk_q[1] & ~bclk_q[2];
  assign w_lr         = lr_sync_q[1];
  assign w_sd         = sd_sync_q[1];
  assign w_slot_start = w_rise & (w_lr != lr_prev_q);
  assign w_idx_next   = w_slot_start ? '0 :
                        (bit_idx_q == c_idx_max) ? c_idx_max : bit_idx_q + 1'b1;
  assign w_word_done  = w_rise & (w_idx_next == c_sw_idx);
  assign w_short      = bit_idx_q < c_sw_idx;
  assign w_word       = {shift_q, w_sd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_prev_q <= 1'b0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else if (w_rise) begin
      lr_prev_q <= w_lr;
      bit_idx_q <= w_idx_next;
      // The final bit is taken straight from w_sd, so only SAMPLE_WIDTH-1 are held
      if ((w_idx_next != '0) && (w_idx_next < c_sw_idx)) begin
        shift_q <= {shift_q[SAMPLE_WIDTH-3:0], w_sd};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYNC_WAIT;
      left_q    <= '0;
      push_q    <= 1'b0;
      pair_q    <= '0;
      short_err <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (clr_flags) begin
        short_err <= 1'b0;
      end
      if (!en) begin
        state_q <= SYNC_WAIT;
      end else begin
        case (state_q)
          SYNC_WAIT: if (w_slot_start && !w_lr) state_q <= LEFT;
          LEFT: begin
            if (w_word_done) begin
              left_q <= w_word;
            end else if (w_slot_start) begin
              if (w_short) begin
                short_err <= 1'b1;
                state_q   <= SYNC_WAIT;
              end else begin
                state_q <= RIGHT;
              end
            end
          end
          RIGHT: begin
            // Any LR edge seen here precedes the last right bit, so it is short
            if (w_word_done) begin
              push_q  <= 1'b1;
              pair_q  <= {left_q, w_word};
              state_q <= WAIT_L;
            end else if (w_slot_start) begin
              short_err <= 1'b1;
              state_q   <= LEFT;
            end
          end
          WAIT_L:    if (w_slot_start && !w_lr) state_q <= LEFT;
          default:   state_q <= SYNC_WAIT;
        endcase
      end
    end
  end

  assign w_full    = (level_q == c_full);
  assign m_valid   = (level_q != '0);
  assign w_pop     = m_valid & m_ready;
  assign w_push_ok = push_q & (~w_full | w_pop);
  assign w_level_d = level_q + LW'(w_push_ok) - LW'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        mem_q[wr_ptr_q] <= pair_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= w_level_d;
      if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (push_q && w_full && !w_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign m_data     = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

endmodule

`default_nettype wire
